font_rom_arbiter: RTL and testbench

FONT_ROM_ARBITER -- requirements
Module: font_rom_arbiter

---
 rtl/font_rom_arbiter.sv | 156 +++++++++++++++
 tb/tb_font_rom_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/font_rom_arbiter.sv
// Three-way round-robin arbiter for one shared font ROM.
// The owner's digit and row go to the ROM. The returned row is reduced to one
// registered pixel. Ownership rotates after HOLD_MAX cycles, but only when
// another requester is waiting.
module font_rom_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [3:0] bcd0,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd2,
    input  logic [3:0] row0,
    input  logic [3:0] row1,
    input  logic [3:0] row2,
    input  logic [2:0] col0,
    input  logic [2:0] col1,
    input  logic [2:0] col2,
    output logic [3:0] rom_char,
    output logic [3:0] rom_row,
    input  logic [7:0] rom_data,
    output logic [2:0] gnt,
    output logic       pix_valid,
    output logic [1:0] pix_id,
    output logic       pix_bit,
    output logic       busy
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t     state;
    logic [1:0] owner;
    logic [1:0] ptr;
    logic [3:0] hold_cnt;

    logic [3:0] sel_bcd;
    logic [3:0] sel_row;
    logic [2:0] sel_col;
    logic [2:0] bit_idx;
    logic       own_req;
    logic [2:0] others;
    logic [1:0] win;

    // Requester index that follows x, modulo 3.
    function automatic logic [1:0] rr_next(input logic [1:0] x);
        return (x >= 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Search order after last: last+1, then last+2, then last itself.
    // The caller only uses the result when mask is non-zero.
    function automatic logic [1:0] rr_pick(input logic [2:0] mask, input logic [1:0] last);
        logic [1:0] c1, c2, c3;
        c1 = rr_next(last);
        c2 = rr_next(c1);
        c3 = rr_next(c2);
        if (mask[c1])      return c1;
        else if (mask[c2]) return c2;
        else               return c3;
    endfunction

    // Select the owner's digit, row and column.
    always_comb begin
        sel_bcd = bcd0;
        sel_row = row0;
        sel_col = col0;
        case (owner)
            2'd1:    begin sel_bcd = bcd1; sel_row = row1; sel_col = col1; end
            2'd2:    begin sel_bcd = bcd2; sel_row = row2; sel_col = col2; end
            default: ;
        endcase
    end

    // The ROM address is driven only while someone owns the ROM.
    // Non-BCD digit codes select the blank glyph.
    always_comb begin
        rom_char = 4'd0;
        rom_row  = 4'd0;
        if (state == OWN) begin
            rom_char = (sel_bcd > 4'd9) ? 4'hA : sel_bcd;
            rom_row  = sel_row;
        end
    end

    // Pick the next winner.
    // A rotation after a full hold excludes the current owner.
    // Every other decision considers the whole request vector.
    always_comb begin
        bit_idx = 3'd7 - sel_col;
        own_req = req[owner];
        others  = req & ~(3'b001 << owner);
        win     = rr_pick(req, ptr);
        if (state == OWN && own_req)
            win = rr_pick(others, ptr);
    end

    assign busy = (state == OWN);

    // Arbitration FSM, hold counter and registered pixel output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            gnt       <= 3'b000;
            owner     <= 2'd0;
            ptr       <= 2'd2;
            hold_cnt  <= 4'd0;
            pix_valid <= 1'b0;
            pix_id    <= 2'd0;
            pix_bit   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pix_valid <= 1'b0;
                    if (|req) begin
                        state    <= OWN;
                        gnt      <= 3'b001 << win;
                        owner    <= win;
                        ptr      <= win;
                        hold_cnt <= 4'd1;
                    end else begin
                        gnt <= 3'b000;
                    end
                end
                OWN: begin
                    if (own_req) begin
                        pix_valid <= 1'b1;
                        pix_id    <= owner;
                        pix_bit   <= rom_data[bit_idx];
                        if (hold_cnt < 4'(HOLD_MAX)) begin
                            hold_cnt <= hold_cnt + 4'd1;
                        end else if (|others) begin
                            gnt      <= 3'b001 << win;
                            owner    <= win;
                            ptr      <= win;
                            hold_cnt <= 4'd1;
                        end
                    end else begin
                        pix_valid <= 1'b0;
                        if (|req) begin
                            gnt      <= 3'b001 << win;
                            owner    <= win;
                            ptr      <= win;
                            hold_cnt <= 4'd1;
                        end else begin
                            state    <= IDLE;
                            gnt      <= 3'b000;
                            hold_cnt <= 4'd0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Bench for font_rom_arbiter.
// Directed scenarios push the expected pixel for each owned cycle into a queue.
// A negedge monitor pops one entry per pix_valid and compares it.
// Grant, busy and ROM-address checks run just after each rising edge.
module tb_font_rom_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req;
    logic [3:0] bcd0, bcd1, bcd2;
    logic [3:0] row0, row1, row2;
    logic [2:0] col0, col1, col2;
    logic [3:0] rom_char, rom_row;
    logic [7:0] rom_data;
    logic [2:0] gnt;
    logic       pix_valid;
    logic [1:0] pix_id;
    logic       pix_bit;
    logic       busy;

    // ROM stand-in: a fixed row, or {char, row} so the data tracks the address.
    logic       use_fixed;
    logic [7:0] rom_fixed;
    assign rom_data = use_fixed ? rom_fixed : {rom_char, rom_row};

    always #5 clk = ~clk;

    font_rom_arbiter #(.HOLD_MAX(8)) dut (
        .clk(clk), .reset(reset), .req(req),
        .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2),
        .row0(row0), .row1(row1), .row2(row2),
        .col0(col0), .col1(col1), .col2(col2),
        .rom_char(rom_char), .rom_row(rom_row), .rom_data(rom_data),
        .gnt(gnt), .pix_valid(pix_valid), .pix_id(pix_id),
        .pix_bit(pix_bit), .busy(busy)
    );

    typedef struct {
        logic [1:0] id;
        logic       b;
    } pix_t;

    pix_t       sbq[$];
    int         checks   = 0;
    int         failures = 0;
    logic [2:0] cur_gnt;
    logic       exp_bit [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [2:0] g);
        return g[1] ? 2'd1 : (g[2] ? 2'd2 : 2'd0);
    endfunction

    // One clock.
    // If the expected owner is still requesting, queue its pixel for the next edge.
    // Then check the grant that edge should produce.
    task automatic tick(input logic [2:0] eg);
        logic pushed;
        pix_t e;
        pushed = 1'b0;
        if (reset && (cur_gnt & req) != 3'b000) begin
            e.id = idx_of(cur_gnt);
            e.b  = exp_bit[idx_of(cur_gnt)];
            sbq.push_back(e);
            pushed = 1'b1;
        end
        @(posedge clk); #1;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("busy", 32'(busy), 32'(|eg));
        chk("pix_valid", 32'(pix_valid), 32'(pushed));
        cur_gnt = eg;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(3'b000);
        tick(3'b000);
        chk("rst_pix_id", 32'(pix_id), 32'd0);
        chk("rst_pix_bit", 32'(pix_bit), 32'd0);
        chk("rst_rom_char", 32'(rom_char), 32'd0);
        chk("rst_rom_row", 32'(rom_row), 32'd0);
        reset = 1'b1;
    endtask

    // Monitor: each valid pixel must match the oldest queued expectation.
    always @(negedge clk) begin
        if (pix_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pix_unexpected actual id=%0d bit=%0d required=none t=%0t",
                         pix_id, pix_bit, $time);
            end else begin
                pix_t e;
                e = sbq.pop_front();
                chk("pix_id", 32'(pix_id), 32'(e.id));
                chk("pix_bit", 32'(pix_bit), 32'(e.b));
            end
        end
    end

    initial begin
        logic [2:0] eg;
        reset = 1'b0; req = 3'b000; cur_gnt = 3'b000;
        bcd0 = 4'd0; bcd1 = 4'd0; bcd2 = 4'd0;
        row0 = 4'd0; row1 = 4'd0; row2 = 4'd0;
        col0 = 3'd0; col1 = 3'd0; col2 = 3'd0;
        use_fixed = 1'b0; rom_fixed = 8'h00;
        exp_bit[0] = 1'b0; exp_bit[1] = 1'b0; exp_bit[2] = 1'b0;
        do_reset();

        // Single requester: digit 5, row 3, leftmost column against ROM row 0x80.
        use_fixed = 1'b1; rom_fixed = 8'h80;
        bcd0 = 4'd5; row0 = 4'd3; col0 = 3'd0; exp_bit[0] = 1'b1;
        req = 3'b001;
        tick(3'b001);
        chk("rom_char_5", 32'(rom_char), 32'd5);
        chk("rom_row_3", 32'(rom_row), 32'd3);
        tick(3'b001);
        chk("first_pix_id", 32'(pix_id), 32'd0);
        chk("first_pix_bit", 32'(pix_bit), 32'd1);
        req = 3'b000;
        tick(3'b000);
        tick(3'b000);

        // Setup for the next scenarios.
        // With ROM data = {char, row=0}, the expected bits are:
        //   requester 0: bcd=1 -> data 0x10, col 3 -> bit 4 = 1
        //   requester 1: bcd=2 -> data 0x20, col 3 -> bit 4 = 0
        //   requester 2: bcd=4 -> data 0x40, col 1 -> bit 6 = 1
        use_fixed = 1'b0;
        bcd0 = 4'd1; row0 = 4'd0; col0 = 3'd3; exp_bit[0] = 1'b1;
        bcd1 = 4'd2; row1 = 4'd0; col1 = 3'd3; exp_bit[1] = 1'b0;
        bcd2 = 4'd4; row2 = 4'd0; col2 = 3'd1; exp_bit[2] = 1'b1;

        // All three requesting: 8 cycles each in order 0, 1, 2, 0, with no gap.
        do_reset();
        req = 3'b111;
        for (int i = 0; i < 30; i++) begin
            eg = 3'b001 << ((i / 8) % 3);
            tick(eg);
            if (i % 8 == 0)
                chk("rr_rom_char", 32'(rom_char), (eg == 3'b001) ? 32'd1 : (eg == 3'b010) ? 32'd2 : 32'd4);
        end
        req = 3'b000;
        tick(3'b000);

        // Owner 1 releases with requester 2 waiting, then owner 2 hands back to 1.
        // Owner 1 then releases into an empty request vector.
        do_reset();
        req = 3'b010; tick(3'b010);
        req = 3'b110; tick(3'b010);
        req = 3'b100; tick(3'b100);
        req = 3'b010; tick(3'b010);
        req = 3'b000; tick(3'b000);
        chk("idle_rom_char", 32'(rom_char), 32'd0);

        // Requester 2 alone for 40 cycles keeps the grant.
        // Once requester 0 arrives, ownership moves at the very next edge.
        do_reset();
        req = 3'b100;
        for (int i = 0; i < 40; i++) tick(3'b100);
        req = 3'b101; tick(3'b001);
        req = 3'b000; tick(3'b000);

        // Digit 0xC shows the blank glyph; column 7 reads bit 0 of ROM row 0x01.
        do_reset();
        use_fixed = 1'b1; rom_fixed = 8'h01;
        bcd0 = 4'hC; row0 = 4'd2; col0 = 3'd7; exp_bit[0] = 1'b1;
        req = 3'b001; tick(3'b001);
        chk("blank_rom_char", 32'(rom_char), 32'hA);
        chk("blank_rom_row", 32'(rom_row), 32'd2);
        tick(3'b001);
        req = 3'b000; tick(3'b000);

        // Reset asserted mid-OWN clears everything.
        // After release, requester 0 wins first.
        use_fixed = 1'b0;
        bcd0 = 4'd1; row0 = 4'd0; col0 = 3'd3; exp_bit[0] = 1'b1;
        do_reset();
        req = 3'b110; tick(3'b010);
        tick(3'b010);
        do_reset();
        req = 3'b111; tick(3'b001);
        req = 3'b000; tick(3'b000);
        tick(3'b000);

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
